// File: rtl/periodic_framer_mc.sv
// Periodic framer: after a trigger, skips an offset, then alternates cyclic-prefix gaps
// and fixed-length frames for a programmable (or per-trigger) number of frames.
module periodic_framer_mc #(
   parameter int         WIDTH         = 32,
   parameter int         LEN_WIDTH     = 16,
   parameter int         CNT_WIDTH     = 16,
   parameter logic [7:0] SR_FRAME_LEN  = 8'd16,
   parameter logic [7:0] SR_GAP_LEN    = 8'd17,
   parameter logic [7:0] SR_OFFSET     = 8'd18,
   parameter logic [7:0] SR_MAX_FRAMES = 8'd19,
   parameter logic [7:0] SR_FIRST_GAP  = 8'd20,
   parameter logic [7:0] SR_MODE       = 8'd21
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 set_stb,
   input  logic [7:0]           set_addr,
   input  logic [31:0]          set_data,
   input  logic [WIDTH-1:0]     i_tdata,
   input  logic                 i_trigger,
   input  logic [CNT_WIDTH-1:0] i_trig_frames,
   input  logic                 i_tvalid,
   output logic                 i_tready,
   output logic [WIDTH-1:0]     o_tdata,
   output logic                 o_tlast,
   output logic                 o_teob,
   output logic                 o_tvalid,
   input  logic                 o_tready,
   output logic                 o_busy,
   output logic [CNT_WIDTH-1:0] o_frame_idx,
   output logic [15:0]          o_retrig_cnt
);

   typedef enum logic [1:0] {IDLE, OFFSET, GAP, FRAME} state_t;

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

   state_t state, state_nxt, p_state, start_state;
   logic [LEN_WIDTH-1:0] frame_len_r, gap_len_r, offset_r, first_gap_r;
   logic [CNT_WIDTH-1:0] max_frames_r;
   logic                 keep_gap_r, use_first_r;
   logic [LEN_WIDTH-1:0] sh_frame_last, sh_gap, sh_first_gap, sh_offset;
   logic [CNT_WIDTH-1:0] sh_count;
   logic                 sh_keep, sh_use_first;
   logic [LEN_WIDTH-1:0] cnt, cnt_nxt, p_cnt;
   logic [CNT_WIDTH-1:0] frame_idx, fidx_nxt, p_fidx, fidx_inc;
   logic [LEN_WIDTH-1:0] ld_frame_last, a_frame_last, a_gap, a_first_gap, a_offset, gap_cur, gap_next;
   logic [CNT_WIDTH-1:0] ld_count, a_count;
   logic                 a_use_first, passing, hs, ld;
   logic                 unused_set_data;

   assign unused_set_data = ^set_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_len_r  <= '0;
         gap_len_r    <= '0;
         offset_r     <= '0;
         max_frames_r <= '0;
         first_gap_r  <= '0;
         keep_gap_r   <= 1'b0;
         use_first_r  <= 1'b0;
      end else if (set_stb) begin
         case (set_addr)
            SR_FRAME_LEN:  frame_len_r  <= set_data[LEN_WIDTH-1:0];
            SR_GAP_LEN:    gap_len_r    <= set_data[LEN_WIDTH-1:0];
            SR_OFFSET:     offset_r     <= set_data[LEN_WIDTH-1:0];
            SR_MAX_FRAMES: max_frames_r <= set_data[CNT_WIDTH-1:0];
            SR_FIRST_GAP:  first_gap_r  <= set_data[LEN_WIDTH-1:0];
            SR_MODE:       {use_first_r, keep_gap_r} <= set_data[1:0];
            default: ;
         endcase
      end
   end

   // Stream handshake: a beat moves when valid && ready. While passing, the input is
   // wired straight through (ready from downstream, valid from upstream); while
   // discarding, the input is always ready and nothing is offered downstream.
   assign passing  = (state == FRAME) || (state == GAP && sh_keep);
   assign i_tready = passing ? o_tready : 1'b1;
   assign o_tvalid = passing && i_tvalid;
   assign o_tdata  = i_tdata;
   assign hs       = i_tvalid && i_tready;
   assign o_tlast  = (state == FRAME) && (cnt == sh_frame_last);
   assign o_teob   = o_tlast && (sh_count != '0) && ((frame_idx + CNT_ONE) == sh_count);
   assign o_busy   = (state != IDLE);
   assign o_frame_idx = frame_idx;

   // On the trigger beat the fresh settings are used directly so the trigger sample
   // counts as sample 0 of the first non-skipped phase.
   assign ld            = (state == IDLE) && hs && i_trigger;
   assign ld_frame_last = (frame_len_r == '0) ? '0 : frame_len_r - LEN_ONE;
   assign ld_count      = (i_trig_frames != '0) ? i_trig_frames : max_frames_r;
   assign a_frame_last  = ld ? ld_frame_last : sh_frame_last;
   assign a_gap         = ld ? gap_len_r     : sh_gap;
   assign a_first_gap   = ld ? first_gap_r   : sh_first_gap;
   assign a_offset      = ld ? offset_r      : sh_offset;
   assign a_count       = ld ? ld_count      : sh_count;
   assign a_use_first   = ld ? use_first_r   : sh_use_first;
   assign start_state   = (offset_r != '0) ? OFFSET :
                          (((use_first_r ? first_gap_r : gap_len_r) != '0) ? GAP : FRAME);
   assign p_state  = ld ? start_state : state;
   assign p_cnt    = ld ? '0 : cnt;
   assign p_fidx   = ld ? '0 : frame_idx;
   assign fidx_inc = p_fidx + CNT_ONE;
   assign gap_cur  = (a_use_first && p_fidx == '0) ? a_first_gap : a_gap;
   assign gap_next = (a_use_first && fidx_inc == '0) ? a_first_gap : a_gap;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fidx_nxt  = frame_idx;
      if (hs && (ld || state != IDLE)) begin
         state_nxt = p_state;
         cnt_nxt   = p_cnt + LEN_ONE;
         fidx_nxt  = p_fidx;
         case (p_state)
            OFFSET: if (p_cnt == a_offset - LEN_ONE) begin
               cnt_nxt   = '0;
               state_nxt = (gap_cur != '0) ? GAP : FRAME;
            end
            GAP: if (p_cnt == gap_cur - LEN_ONE) begin
               cnt_nxt   = '0;
               state_nxt = FRAME;
            end
            FRAME: if (p_cnt == a_frame_last) begin
               cnt_nxt  = '0;
               fidx_nxt = fidx_inc;
               if (a_count != '0 && fidx_inc == a_count) state_nxt = IDLE;
               else state_nxt = (gap_next != '0) ? GAP : FRAME;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         frame_idx     <= '0;
         sh_frame_last <= '0;
         sh_gap        <= '0;
         sh_first_gap  <= '0;
         sh_offset     <= '0;
         sh_count      <= '0;
         sh_keep       <= 1'b0;
         sh_use_first  <= 1'b0;
      end else if (clear) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         frame_idx <= fidx_nxt;
         if (ld) begin
            sh_frame_last <= ld_frame_last;
            sh_gap        <= gap_len_r;
            sh_first_gap  <= first_gap_r;
            sh_offset     <= offset_r;
            sh_count      <= ld_count;
            sh_keep       <= keep_gap_r;
            sh_use_first  <= use_first_r;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) o_retrig_cnt <= '0;
      else if (state != IDLE && hs && i_trigger && o_retrig_cnt != 16'hFFFF)
         o_retrig_cnt <= o_retrig_cnt + 16'd1;
   end

endmodule

// File: tb/tb_periodic_framer_mc.sv
// Bench for periodic_framer_mc: randomized stream against a position-based burst model,
// plus an expected-sample scoreboard and literal checks of frame positions.
module tb_periodic_framer_mc;
   localparam int W  = 32;
   localparam int LW = 16;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1, clear = 1'b0, set_stb = 1'b0;
   logic [7:0]    set_addr = '0;
   logic [31:0]   set_data = '0;
   logic [W-1:0]  i_tdata = '0;
   logic          i_trigger = 1'b0, i_tvalid = 1'b0, o_tready = 1'b1;
   logic [CW-1:0] i_trig_frames = '0;
   logic          i_tready, o_tlast, o_teob, o_tvalid, o_busy;
   logic [W-1:0]  o_tdata;
   logic [CW-1:0] o_frame_idx;
   logic [15:0]   o_retrig_cnt;

   always #5 clk = ~clk;

   periodic_framer_mc dut (
      .clk(clk), .reset(reset), .clear(clear),
      .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .i_tdata(i_tdata), .i_trigger(i_trigger), .i_trig_frames(i_trig_frames),
      .i_tvalid(i_tvalid), .i_tready(i_tready),
      .o_tdata(o_tdata), .o_tlast(o_tlast), .o_teob(o_teob), .o_tvalid(o_tvalid),
      .o_tready(o_tready), .o_busy(o_busy), .o_frame_idx(o_frame_idx),
      .o_retrig_cnt(o_retrig_cnt)
   );

   int n_cmp = 0, n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_set_fl = 0, m_set_gap = 0, m_set_off = 0, m_set_max = 0, m_set_fg = 0;
   bit m_set_keep = 0, m_set_uf = 0;
   int m_fl = 1, m_gap = 0, m_fg = 0, m_off = 0, m_cnt = 0;
   bit m_keep = 0, m_uf = 0;
   bit m_busy = 0;
   int m_r = 0, m_fidx_idle = 0, m_retrig = 0;

   // Where does burst-relative input sample r land? Walks offset, then gap/frame pairs.
   function automatic void classify(input int r, output bit pass, output bit last,
                                    output bit eob, output int k);
      int pos;
      int g;
      pos = r;
      pass = 0; last = 0; eob = 0; k = 0;
      if (pos < m_off) return;
      pos -= m_off;
      while (1) begin
         g = (k == 0 && m_uf) ? m_fg : m_gap;
         if (pos < g) begin
            pass = m_keep;
            return;
         end
         pos -= g;
         if (pos < m_fl) begin
            pass = 1;
            last = (pos == m_fl - 1);
            eob  = last && (m_cnt != 0) && (k == m_cnt - 1);
            return;
         end
         pos -= m_fl;
         k++;
      end
   endfunction

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int           starts_q[$];
   logic [W-1:0] trig_seq = '0;
   bit           sb_en = 0, prev_last = 1;
   int           eob_seen = 0, tlast_seen = 0, beats_seen = 0;
   bit           dut_hs = 0;

   always @(negedge clk) begin
      bit e_pass, e_last, e_eob, in_pass, hs_m, p0, l0, e0;
      int e_k, k0;
      logic e_tready, e_tvalid;
      logic [W-1:0] rel;
      e_pass = 0; e_last = 0; e_eob = 0; e_k = 0;
      if (m_busy) classify(m_r, e_pass, e_last, e_eob, e_k);
      in_pass  = m_busy && e_pass;
      e_tready = in_pass ? o_tready : 1'b1;
      e_tvalid = in_pass && i_tvalid;

      chk("i_tready", i_tready, e_tready);
      chk("o_tvalid", o_tvalid, e_tvalid);
      chk("o_busy", o_busy, m_busy);
      chk("o_frame_idx", o_frame_idx, m_busy ? CW'(e_k) : CW'(m_fidx_idle));
      chk("o_retrig_cnt", o_retrig_cnt, 16'(m_retrig));
      if (e_tvalid) begin
         chk("o_tdata", o_tdata, i_tdata);
         chk("o_tlast", o_tlast, e_last);
         chk("o_teob", o_teob, e_eob);
      end

      if (sb_en && o_tvalid && o_tready) begin
         rel = o_tdata - trig_seq;
         if (exp_q.size() == 0) chk("sb_extra_beat", rel, 64'hFFFF_FFFF_FFFF_FFFF);
         else chk("sb_sample", rel, exp_q.pop_front());
         if (prev_last) starts_q.push_back(int'(rel));
         prev_last = o_tlast;
         beats_seen++;
         if (o_tlast) tlast_seen++;
         if (o_teob) eob_seen++;
      end

      dut_hs = i_tvalid && i_tready;
      hs_m   = i_tvalid && e_tready;
      if (reset) begin
         m_set_fl = 0; m_set_gap = 0; m_set_off = 0; m_set_max = 0; m_set_fg = 0;
         m_set_keep = 0; m_set_uf = 0;
         m_busy = 0; m_r = 0; m_fidx_idle = 0; m_retrig = 0;
      end else begin
         if (m_busy && hs_m && i_trigger && m_retrig < 65535) m_retrig++;
         if (clear) begin
            if (m_busy) m_fidx_idle = e_k;
            m_busy = 0;
         end else if (m_busy && hs_m) begin
            if (e_eob) begin
               m_busy = 0;
               m_fidx_idle = e_k + 1;
            end else m_r++;
         end else if (!m_busy && hs_m && i_trigger) begin
            m_fl = (m_set_fl == 0) ? 1 : m_set_fl;
            m_gap = m_set_gap; m_fg = m_set_fg; m_off = m_set_off;
            m_cnt = (i_trig_frames != 0) ? int'(i_trig_frames) : m_set_max;
            m_keep = m_set_keep; m_uf = m_set_uf;
            classify(0, p0, l0, e0, k0);
            if (e0) m_fidx_idle = k0 + 1;
            else begin
               m_busy = 1;
               m_r = 1;
            end
         end
         if (set_stb) begin
            case (set_addr)
               8'd16: m_set_fl  = int'(set_data[LW-1:0]);
               8'd17: m_set_gap = int'(set_data[LW-1:0]);
               8'd18: m_set_off = int'(set_data[LW-1:0]);
               8'd19: m_set_max = int'(set_data[CW-1:0]);
               8'd20: m_set_fg  = int'(set_data[LW-1:0]);
               8'd21: begin m_set_keep = set_data[0]; m_set_uf = set_data[1]; end
               default: ;
            endcase
         end
      end
   end

   // ---------------- driver ----------------
   logic [W-1:0] seq = '0;
   int vprob = 100, rprob = 100;

   task automatic tick();
      @(posedge clk);
      if (dut_hs) seq++;
      #1;
      i_tdata = seq;
      if (!i_tvalid || dut_hs) i_tvalid = ($urandom_range(0, 99) < vprob);
      o_tready = ($urandom_range(0, 99) < rprob);
      i_trigger = 1'b0; i_trig_frames = '0; set_stb = 1'b0; clear = 1'b0;
   endtask

   task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
      tick();
      set_stb = 1'b1; set_addr = a; set_data = d;
   endtask

   task automatic configure(input int fl, input int gap, input int off, input int mx,
                            input int fg, input int mode);
      set_reg(8'd16, fl); set_reg(8'd17, gap); set_reg(8'd18, off);
      set_reg(8'd19, mx); set_reg(8'd20, fg); set_reg(8'd21, mode);
   endtask

   task automatic trigger(input int frames);
      tick();
      i_trigger = 1'b1; i_tvalid = 1'b1; i_trig_frames = CW'(frames); trig_seq = seq;
   endtask

   task automatic arm_sb();
      exp_q.delete(); starts_q.delete();
      sb_en = 1; prev_last = 1; eob_seen = 0; tlast_seen = 0; beats_seen = 0;
   endtask

   task automatic push_frames(input int first, input int period, input int len, input int n);
      for (int k = 0; k < n; k++)
         for (int j = 0; j < len; j++) exp_q.push_back(W'(first + k * period + j));
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (o_busy && n < budget);
      chk("burst_timeout", n < budget, 1);
      tick();
      sb_en = 0;
      chk("sb_leftover", exp_q.size(), 0);
   endtask

   task automatic idle_ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1;
      idle_ticks(3);
      #1;
      chk("rst_o_tvalid", o_tvalid, 0);
      chk("rst_i_tready", i_tready, 1);
      chk("rst_o_busy", o_busy, 0);
      chk("rst_o_retrig", o_retrig_cnt, 0);
      chk("rst_o_fidx", o_frame_idx, 0);
      reset = 1'b0;

      // 12 frames of 64, gap 16, offset 69
      configure(64, 16, 69, 12, 0, 0);
      arm_sb(); push_frames(85, 80, 64, 12);
      trigger(0);
      wait_idle(3000);
      chk("a_nframes", starts_q.size(), 12);
      if (starts_q.size() == 12) begin
         chk("a_start0", starts_q[0], 85);
         chk("a_start11", starts_q[11], 965);
      end
      chk("a_eob_count", eob_seen, 1);
      chk("a_tlast_count", tlast_seen, 12);
      chk("a_fidx_end", o_frame_idx, 12);
      idle_ticks(5);

      // per-trigger override of 3 frames
      arm_sb(); push_frames(85, 80, 64, 3);
      trigger(3);
      wait_idle(1000);
      chk("b_tlast_count", tlast_seen, 3);
      chk("b_eob_count", eob_seen, 1);
      idle_ticks(5);

      // next trigger falls back to max=12, with input gaps and 50% output stalls
      vprob = 70; rprob = 50;
      arm_sb(); push_frames(85, 80, 64, 12);
      trigger(0);
      wait_idle(10000);
      chk("c_nframes", starts_q.size(), 12);
      if (starts_q.size() == 12) chk("c_start11", starts_q[11], 965);
      chk("c_beats", beats_seen, 768);
      vprob = 80; rprob = 80;
      idle_ticks(5);

      // long first gap
      configure(64, 16, 0, 2, 20, 2);
      arm_sb(); push_frames(20, 80, 64, 2);
      trigger(0);
      wait_idle(2000);
      chk("d_nframes", starts_q.size(), 2);
      if (starts_q.size() == 2) begin
         chk("d_start0", starts_q[0], 20);
         chk("d_start1", starts_q[1], 100);
      end
      idle_ticks(5);

      // keep_gap: 80-sample packets
      configure(64, 16, 5, 2, 0, 1);
      arm_sb(); push_frames(5, 160, 160, 1);
      trigger(0);
      wait_idle(2000);
      chk("e_packets", tlast_seen, 2);
      chk("e_beats", beats_seen, 160);
      if (starts_q.size() == 2) chk("e_pkt1_start", starts_q[1], 85);
      else chk("e_npkts", starts_q.size(), 2);
      idle_ticks(5);

      // continuous, retrigger, clear mid-frame
      vprob = 100; rprob = 100;
      configure(10, 4, 3, 0, 0, 0);
      trigger(0);
      idle_ticks(100);
      chk("f_still_busy", o_busy, 1);
      tick();
      i_trigger = 1'b1; i_tvalid = 1'b1;
      idle_ticks(3);
      chk("f_retrig_lit", o_retrig_cnt, 1);
      n = 0;
      do begin
         tick();
         #1;
         n++;
      end while (!(o_tvalid && o_tready && !o_tlast) && n < 50);
      chk("f_midframe_found", n < 50, 1);
      clear = 1'b1;
      tick();
      #1;
      chk("f_clear_tvalid", o_tvalid, 0);
      chk("f_clear_busy", o_busy, 0);
      idle_ticks(5);

      // settings write in the trigger cycle; gap 0
      configure(8, 0, 2, 1, 0, 0);
      arm_sb(); push_frames(2, 8, 8, 1);
      trigger(0);
      set_stb = 1'b1; set_addr = 8'd16; set_data = 32'd20;
      wait_idle(200);
      chk("g_tlast_count", tlast_seen, 1);
      chk("g_beats", beats_seen, 8);
      idle_ticks(5);

      // frame_len 0 acts as 1
      vprob = 80; rprob = 60;
      configure(0, 1, 1, 3, 0, 0);
      arm_sb(); push_frames(2, 2, 1, 3);
      trigger(0);
      wait_idle(200);
      chk("h_tlast_count", tlast_seen, 3);
      chk("h_eob_count", eob_seen, 1);
      idle_ticks(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/periodic_framer_mc.md
# periodic_framer_mc

Parametrised periodic framer that follows a Schmidl-Cox style burst detector in the RFNoC receive chain. On a per-sample trigger it skips a programmable offset, then repeatedly discards a cyclic-prefix gap and passes one frame of samples (FFT symbol) to the downstream FFT, up to a programmable frame count. Compared with the first-generation framer, it adds:
- generic sample width and counter width;
- a separate first-gap length, for long-CP first symbols;
- a per-trigger frame-count override;
- a keep-gap mode;
- shadowed settings;
- end-of-burst and status outputs.

## Interface
Parameters:
- WIDTH, 32, sample width (i_tdata/o_tdata).
- LEN_WIDTH, 16, width of frame_len, gap_len, first_gap_len and offset settings and counters.
- CNT_WIDTH, 16, width of frame-count settings and counter.
- SR_FRAME_LEN, 16, settings address of frame_len.
- SR_GAP_LEN, 17, settings address of gap_len.
- SR_OFFSET, 18, settings address of offset.
- SR_MAX_FRAMES, 19, settings address of default frame count.
- SR_FIRST_GAP, 20, settings address of first_gap_len.
- SR_MODE, 21, settings address of mode: bit0 keep_gap, bit1 use_first_gap.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - clk, in, 1, clock.
  - reset, in, 1, reset; clears all state and settings.
  - clear, in, 1, synchronous soft clear: returns the FSM to IDLE but keeps the settings.
- Settings bus:
  - set_stb, in, 1, settings write strobe.
  - set_addr, in, 8, settings address.
  - set_data, in, 32, settings data; the low LEN_WIDTH or CNT_WIDTH bits are used.
- Input stream:
  - i_tdata, in, WIDTH, input sample.
  - i_trigger, in, 1, sideband qualified by the i_tvalid&&i_tready handshake; marks a burst start.
  - i_trig_frames, in, CNT_WIDTH, sideband qualified with i_trigger; nonzero overrides the frame count.
  - i_tvalid, in, 1; i_tready, out, 1; input handshake.
- Output stream:
  - o_tdata, out, WIDTH, output sample.
  - o_tlast, out, 1, last sample of each frame.
  - o_teob, out, 1, asserted with o_tlast on the final frame of a burst.
  - o_tvalid, out, 1; o_tready, in, 1; output handshake.
- Status:
  - o_busy, out, 1, high outside IDLE.
  - o_frame_idx, out, CNT_WIDTH, index of the current frame (0-based).
  - o_retrig_cnt, out, 16, saturating count of triggers ignored during a burst.

## Operation
- Settings are written on set_stb with a matching set_addr.
  - All settings reset to 0.
  - Settings are copied into shadow registers on an accepted trigger, so writes during a burst affect only the next burst.
- Value rules, applied at shadow load:
  - frame_len=0 is treated as 1.
  - A gap, first gap or offset of 0 means that phase is skipped.
  - Effective frame count is i_trig_frames if nonzero, else max_frames.
  - An effective frame count of 0 means continuous: frames repeat until clear or reset.
- FSM states: IDLE, OFFSET, GAP, FRAME.
  - IDLE:
    - i_tready=1 and samples are discarded.
    - A handshake with i_trigger=1 loads the shadows and frame_idx=0.
    - The trigger sample is counted as sample 0 of the first non-skipped phase: OFFSET, then GAP, then FRAME.
  - OFFSET:
    - Discards the offset samples, including the trigger sample.
    - Exits to GAP, or to FRAME if the gap is 0.
  - GAP:
    - Length is first_gap_len for frame_idx=0 when use_first_gap=1, else gap_len.
    - With keep_gap=0, samples are discarded and i_tready=1.
    - With keep_gap=1, samples are passed as in FRAME, with no o_tlast.
  - FRAME:
    - Passes frame_len samples; o_tlast is asserted on the last one.
    - After the last sample, frame_idx increments. If frame_idx+1 equals the count (count≠0), o_teob is asserted with that o_tlast and the FSM goes to IDLE; otherwise it goes to GAP (or FRAME if the gap is 0).
- i_trigger outside IDLE is ignored and increments o_retrig_cnt, which saturates at 0xFFFF.
- Counters advance only on accepted input handshakes. Each counter compares against its length minus 1, in LEN_WIDTH arithmetic with no wrap.

## Timing
- Zero-latency combinational data path:
  - While passing (FRAME, or GAP with keep_gap): o_tdata=i_tdata, o_tvalid=i_tvalid, i_tready=o_tready.
  - While discarding: o_tvalid=0 and i_tready=1.
- Output values during and after reset: o_tvalid=0, o_tlast=0, o_teob=0, o_busy=0, o_frame_idx=0, o_retrig_cnt=0, i_tready=1 (IDLE).
- State, counters and frame_idx update on the clock edge of the handshake.
  - o_busy rises on the cycle after the trigger handshake.
  - o_busy falls on the cycle after the eob handshake.
- An output stall (o_tready=0) holds all counters. o_tdata and o_tlast must stay stable while o_tvalid=1 and o_tready=0.
- Clear or reset during a burst takes effect on the next edge. A partially sent frame is abandoned without o_tlast.
- A settings write in the same cycle as a trigger handshake: the shadow takes the old value.

## Test plan
- Settings frame_len=64, gap=16, offset=69, max=12; trigger on sample 0 → 12 frames of 64 samples. Frame k starts at input sample 69+16+k*80. Only frame 11 has o_teob; o_busy drops afterwards.
- Same settings with i_trig_frames=3 on the trigger → 3 frames; o_teob on the 3rd frame; the next trigger uses max=12.
- use_first_gap=1, first_gap=20, gap=16, offset=0 → frame 0 starts at trigger+20, frame 1 starts at trigger+20+64+16.
- keep_gap=1, gap=16, frame=64, max=2 → 80-sample packets on output, with o_tlast on the 80th sample; 2 packets total.
- max=0 (continuous) → frames continue; a retrigger mid-burst makes o_retrig_cnt=1; clear mid-frame → o_tvalid=0 on the next cycle and the FSM is in IDLE.
- Random o_tready backpressure at 50% with the first-scenario settings → the output sample sequence is identical to the no-stall run, and no samples are dropped or duplicated.
